// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding unit for an in-order pipeline.
// Generates per-source forwarding mux selects and stalls the front end on
// load-use hazards and on hazards against in-flight multi-cycle results.
module hazard_fwd_unit #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    ex_rs,
    input  logic [NUM_SRC-1:0]               ex_rs_used,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]               id_rs_used,
    input  logic [REG_ADDR_W-1:0]            id_rd,
    input  logic                             id_regWrite,
    input  logic [REG_ADDR_W-1:0]            ex_rd,
    input  logic                             ex_regWrite,
    input  logic                             ex_memRead,
    input  logic [REG_ADDR_W-1:0]            mem_rd,
    input  logic                             mem_regWrite,
    input  logic [REG_ADDR_W-1:0]            wb_rd,
    input  logic                             wb_regWrite,
    input  logic                             mc_issue,
    input  logic [REG_ADDR_W-1:0]            mc_rd,
    input  logic                             mc_done,
    input  logic [REG_ADDR_W-1:0]            mc_done_rd,
    input  logic                             flush,
    output logic [2*NUM_SRC-1:0]             fwd_sel,
    output logic                             stall,
    output logic [(2**REG_ADDR_W)-1:0]       sb_busy,
    output logic [15:0]                      stall_cnt
);

    localparam int NUM_REGS = 2**REG_ADDR_W;
    localparam logic [2:0] LAT_RELOAD = 3'(LOAD_LAT - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        LD_STALL = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;
    logic [2:0]           r_cnt;
    logic [2:0]           w_cntNext;
    logic [NUM_REGS-1:0]  r_sbBusy;
    logic [15:0]          r_stallCnt;

    logic                 w_luMatch;
    logic                 w_sbRead;
    logic                 w_loadUse;
    logic                 w_sbWaw;
    logic                 w_sbHazard;
    logic                 w_stall;

    // Forwarding select per source: the younger MEM result beats the WB result
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_rs_used[i] && mem_regWrite && (mem_rd != '0) &&
                (mem_rd == ex_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
                fwd_sel[2*i +: 2] = 2'b01;
            end else if (ex_rs_used[i] && wb_regWrite && (wb_rd != '0) &&
                         (wb_rd == ex_rs[i*REG_ADDR_W +: REG_ADDR_W])) begin
                fwd_sel[2*i +: 2] = 2'b10;
            end
        end
    end

    // Scan the ID-stage sources against the EX load and the pending-write scoreboard
    always_comb begin
        w_luMatch = 1'b0;
        w_sbRead  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_rs_used[i]) begin
                if (id_rs[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd) begin
                    w_luMatch = 1'b1;
                end
                if (r_sbBusy[id_rs[i*REG_ADDR_W +: REG_ADDR_W]]) begin
                    w_sbRead = 1'b1;
                end
            end
        end
    end

    assign w_loadUse  = ex_memRead && ex_regWrite && (ex_rd != '0) && w_luMatch;
    assign w_sbWaw    = id_regWrite && (id_rd != '0) && r_sbBusy[id_rd];
    assign w_sbHazard = w_sbRead || w_sbWaw;
    assign w_stall    = ((r_state == LD_STALL) || w_loadUse || w_sbHazard) && !flush;

    assign stall     = w_stall;
    assign sb_busy   = r_sbBusy;
    assign stall_cnt = r_stallCnt;

    // Load-use stall sequencer: decide next state and remaining stall cycles
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        if (flush) begin
            w_stateNext = IDLE;
            w_cntNext   = 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_loadUse && (LOAD_LAT > 1)) begin
                        w_stateNext = LD_STALL;
                        w_cntNext   = LAT_RELOAD;
                    end
                end
                LD_STALL: begin
                    if (r_cnt <= 3'd1) begin
                        w_stateNext = IDLE;
                        w_cntNext   = 3'd0;
                    end else begin
                        w_cntNext = r_cnt - 3'd1;
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                    w_cntNext   = 3'd0;
                end
            endcase
        end
    end

    // Sequencer state and counter registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Scoreboard: issue sets a bit, completion clears it, a same-cycle set wins, r0 never busy
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_sbBusy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (mc_issue && (mc_rd == REG_ADDR_W'(i))) begin
                    r_sbBusy[i] <= 1'b1;
                end else if (mc_done && (mc_done_rd == REG_ADDR_W'(i))) begin
                    r_sbBusy[i] <= 1'b0;
                end
            end
            r_sbBusy[0] <= 1'b0;
        end
    end

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_stallCnt <= 16'd0;
        end else if (w_stall && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Testbench for hazard_fwd_unit: directed vectors checked against a
// behavioural model every cycle plus hand-computed literal expectations.
module tb_hazard_fwd_unit;

    localparam int NSRC = 2;
    localparam int AW   = 5;
    localparam int LAT  = 3;

    logic                 clk = 1'b0;
    logic                 rstN;
    logic [NSRC*AW-1:0]   ex_rs;
    logic [NSRC-1:0]      ex_rs_used;
    logic [NSRC*AW-1:0]   id_rs;
    logic [NSRC-1:0]      id_rs_used;
    logic [AW-1:0]        id_rd;
    logic                 id_regWrite;
    logic [AW-1:0]        ex_rd;
    logic                 ex_regWrite;
    logic                 ex_memRead;
    logic [AW-1:0]        mem_rd;
    logic                 mem_regWrite;
    logic [AW-1:0]        wb_rd;
    logic                 wb_regWrite;
    logic                 mc_issue;
    logic [AW-1:0]        mc_rd;
    logic                 mc_done;
    logic [AW-1:0]        mc_done_rd;
    logic                 flush;
    logic [2*NSRC-1:0]    fwd_sel;
    logic                 stall;
    logic [31:0]          sb_busy;
    logic [15:0]          stall_cnt;

    int  nVec   = 0;
    int  nErr   = 0;
    bit  checkEn = 1'b1;

    bit  mSb [32];
    int  mRemain   = 0;
    int  mStallCnt = 0;

    typedef struct {
        logic [9:0] rs;
        logic [1:0] used;
        logic [4:0] mrd;
        logic       mw;
        logic [4:0] wrd;
        logic       ww;
        logic [3:0] exp;
    } fwdVec_t;

    fwdVec_t fv [6];

    hazard_fwd_unit #(
        .NUM_SRC    (NSRC),
        .REG_ADDR_W (AW),
        .LOAD_LAT   (LAT)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .ex_rs        (ex_rs),
        .ex_rs_used   (ex_rs_used),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .id_rd        (id_rd),
        .id_regWrite  (id_regWrite),
        .ex_rd        (ex_rd),
        .ex_regWrite  (ex_regWrite),
        .ex_memRead   (ex_memRead),
        .mem_rd       (mem_rd),
        .mem_regWrite (mem_regWrite),
        .wb_rd        (wb_rd),
        .wb_regWrite  (wb_regWrite),
        .mc_issue     (mc_issue),
        .mc_rd        (mc_rd),
        .mc_done      (mc_done),
        .mc_done_rd   (mc_done_rd),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .sb_busy      (sb_busy),
        .stall_cnt    (stall_cnt)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    function automatic logic [3:0] modelFwd();
        logic [3:0] r;
        logic [4:0] rs;
        r = '0;
        for (int s = 0; s < NSRC; s++) begin
            rs = ex_rs[s*AW +: AW];
            if (ex_rs_used[s] && mem_regWrite && mem_rd != 0 && mem_rd == rs)
                r[2*s +: 2] = 2'b01;
            else if (ex_rs_used[s] && wb_regWrite && wb_rd != 0 && wb_rd == rs)
                r[2*s +: 2] = 2'b10;
        end
        return r;
    endfunction

    function automatic bit modelLu();
        bit hit;
        hit = 1'b0;
        for (int s = 0; s < NSRC; s++)
            if (id_rs_used[s] && id_rs[s*AW +: AW] == ex_rd) hit = 1'b1;
        return ex_memRead && ex_regWrite && ex_rd != 0 && hit;
    endfunction

    function automatic bit modelSbHaz();
        bit hit;
        hit = id_regWrite && id_rd != 0 && mSb[id_rd];
        for (int s = 0; s < NSRC; s++)
            if (id_rs_used[s] && mSb[id_rs[s*AW +: AW]]) hit = 1'b1;
        return hit;
    endfunction

    function automatic bit modelStall();
        return (mRemain > 0 || modelLu() || modelSbHaz()) && !flush;
    endfunction

    function automatic logic [31:0] modelSb();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = mSb[r];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ex_rs = '0; ex_rs_used = '0; id_rs = '0; id_rs_used = '0;
        id_rd = '0; id_regWrite = 0; ex_rd = '0; ex_regWrite = 0; ex_memRead = 0;
        mem_rd = '0; mem_regWrite = 0; wb_rd = '0; wb_regWrite = 0;
        mc_issue = 0; mc_rd = '0; mc_done = 0; mc_done_rd = '0; flush = 0;
    endtask

    task automatic setLoadUse();
        ex_memRead = 1; ex_regWrite = 1; ex_rd = 5'd7;
        id_rs = {5'd7, 5'd0}; id_rs_used = 2'b10;
    endtask

    // Behavioural model: remaining load stall cycles, scoreboard bits, stall counter
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int r = 0; r < 32; r++) mSb[r] <= 1'b0;
            mRemain   <= 0;
            mStallCnt <= 0;
        end else begin
            if (modelStall() && mStallCnt < 65535) mStallCnt <= mStallCnt + 1;
            if (flush) mRemain <= 0;
            else if (mRemain > 0) mRemain <= mRemain - 1;
            else if (modelLu()) mRemain <= LAT - 1;
            if (mc_done) mSb[mc_done_rd] <= 1'b0;
            if (mc_issue && mc_rd != 0) mSb[mc_rd] <= 1'b1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("fwd_sel", 32'(fwd_sel), 32'(modelFwd()));
            checkOutput("stall", 32'(stall), 32'(modelStall()));
            checkOutput("sb_busy", sb_busy, modelSb());
            checkOutput("stall_cnt", 32'(stall_cnt), 32'(mStallCnt));
        end
    end

    // Directed scenario sequence
    initial begin
        fv[0] = '{rs: {5'd12, 5'd5}, used: 2'b01, mrd: 5'd5, mw: 1'b1, wrd: 5'd5,  ww: 1'b1, exp: 4'b0001};
        fv[1] = '{rs: {5'd12, 5'd5}, used: 2'b01, mrd: 5'd5, mw: 1'b0, wrd: 5'd5,  ww: 1'b1, exp: 4'b0010};
        fv[2] = '{rs: {5'd12, 5'd5}, used: 2'b01, mrd: 5'd0, mw: 1'b1, wrd: 5'd0,  ww: 1'b1, exp: 4'b0000};
        fv[3] = '{rs: {5'd12, 5'd5}, used: 2'b11, mrd: 5'd5, mw: 1'b1, wrd: 5'd12, ww: 1'b1, exp: 4'b1001};
        fv[4] = '{rs: {5'd12, 5'd5}, used: 2'b10, mrd: 5'd5, mw: 1'b1, wrd: 5'd12, ww: 1'b1, exp: 4'b1000};
        fv[5] = '{rs: {5'd5, 5'd5},  used: 2'b11, mrd: 5'd5, mw: 1'b1, wrd: 5'd5,  ww: 1'b1, exp: 4'b0101};

        rstN = 1'b0;
        clearInputs();
        applyStimulus();
        ex_rs = {5'd0, 5'd5}; ex_rs_used = 2'b01; mem_rd = 5'd5; mem_regWrite = 1;
        #1;
        checkOutput("rst_fwd", 32'(fwd_sel), 32'h1);
        checkOutput("rst_stall", 32'(stall), 32'h0);
        checkOutput("rst_sb", sb_busy, 32'h0);
        checkOutput("rst_cnt", 32'(stall_cnt), 32'h0);
        applyStimulus();
        rstN = 1'b1;
        clearInputs();
        applyStimulus();

        for (int k = 0; k < 6; k++) begin
            ex_rs = fv[k].rs; ex_rs_used = fv[k].used;
            mem_rd = fv[k].mrd; mem_regWrite = fv[k].mw;
            wb_rd = fv[k].wrd; wb_regWrite = fv[k].ww;
            #1;
            checkOutput($sformatf("fwd_vec%0d", k), 32'(fwd_sel), 32'(fv[k].exp));
            applyStimulus();
        end
        clearInputs();
        applyStimulus();

        ex_memRead = 1; ex_regWrite = 1; ex_rd = 5'd0; id_rs = {5'd0, 5'd0}; id_rs_used = 2'b10;
        #1;
        checkOutput("lu_rd0", 32'(stall), 32'h0);
        applyStimulus();
        ex_rd = 5'd7; id_rs = {5'd7, 5'd0}; id_rs_used = 2'b01;
        #1;
        checkOutput("lu_unused", 32'(stall), 32'h0);
        applyStimulus();

        setLoadUse();
        #1;
        checkOutput("lu_c0", 32'(stall), 32'h1);
        applyStimulus();
        ex_memRead = 0; ex_regWrite = 0; ex_rd = '0;
        #1;
        checkOutput("lu_c1", 32'(stall), 32'h1);
        applyStimulus();
        checkOutput("lu_c2", 32'(stall), 32'h1);
        applyStimulus();
        checkOutput("lu_c3", 32'(stall), 32'h0);
        checkOutput("lu_cnt", 32'(stall_cnt), 32'd3);
        clearInputs();
        applyStimulus();

        rstN = 1'b0;
        applyStimulus();
        rstN = 1'b1;
        setLoadUse();
        #1;
        checkOutput("fl_c0", 32'(stall), 32'h1);
        applyStimulus();
        ex_memRead = 0; ex_regWrite = 0; ex_rd = '0; flush = 1;
        #1;
        checkOutput("fl_c1", 32'(stall), 32'h0);
        applyStimulus();
        flush = 0;
        #1;
        checkOutput("fl_c2", 32'(stall), 32'h0);
        checkOutput("fl_cnt", 32'(stall_cnt), 32'd1);
        clearInputs();
        applyStimulus();

        mc_issue = 1; mc_rd = 5'd9;
        #1;
        checkOutput("mc_issue_nostall", 32'(stall), 32'h0);
        applyStimulus();
        mc_issue = 0; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        #1;
        checkOutput("sb9_set", 32'(sb_busy[9]), 32'h1);
        checkOutput("sb_raw_c0", 32'(stall), 32'h1);
        applyStimulus();
        id_rs_used = 2'b00; id_regWrite = 1; id_rd = 5'd9;
        #1;
        checkOutput("sb_waw", 32'(stall), 32'h1);
        applyStimulus();
        id_regWrite = 0; id_rd = '0; id_rs_used = 2'b01; mc_done = 1; mc_done_rd = 5'd9;
        #1;
        checkOutput("sb_done_cycle", 32'(stall), 32'h1);
        applyStimulus();
        mc_done = 0; mc_done_rd = '0;
        #1;
        checkOutput("sb_after_done", 32'(stall), 32'h0);
        checkOutput("sb9_clr", 32'(sb_busy[9]), 32'h0);
        clearInputs();
        applyStimulus();

        mc_issue = 1; mc_rd = 5'd4; mc_done = 1; mc_done_rd = 5'd4;
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("sb_set_wins", sb_busy, 32'h0000_0010);
        mc_issue = 1; mc_rd = 5'd0;
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("sb_rd0_issue", sb_busy, 32'h0000_0010);
        mc_issue = 1; mc_rd = 5'd6; mc_done = 1; mc_done_rd = 5'd4;
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("sb_set_clr", sb_busy, 32'h0000_0040);
        mc_done = 1; mc_done_rd = 5'd6;
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("sb_empty", sb_busy, 32'h0);

        mc_issue = 1; mc_rd = 5'd3;
        applyStimulus();
        mc_issue = 0; mc_rd = '0;
        setLoadUse();
        #1;
        checkOutput("ar_lu", 32'(stall), 32'h1);
        applyStimulus();
        ex_memRead = 0; ex_regWrite = 0; ex_rd = '0; id_rs_used = 2'b00;
        #1;
        checkOutput("ar_ldstall", 32'(stall), 32'h1);
        checkOutput("ar_sb3", sb_busy, 32'h0000_0008);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("ar_stall", 32'(stall), 32'h0);
        checkOutput("ar_sb", sb_busy, 32'h0);
        checkOutput("ar_cnt", 32'(stall_cnt), 32'h0);
        applyStimulus();
        rstN = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("ar_after", 32'(stall), 32'h0);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
